// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS main FSM (master) and its datapath (slave).
// Carries the instruction fields and status in, and the per-step selects/enables out.
`timescale 1ns/1ps
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_instr;
    logic       bus_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal_instr, bus_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal_instr, bus_err
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core with memory wait-state timeout.
// Define MIPS_CTRL_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counters.
`timescale 1ns/1ps
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_multicycle_ctrl_if.master   bus,
    output logic [3:0]               state_o
`ifdef MIPS_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic       mem_req_c, i_or_d_c, ir_write_c, mem_write_c, reg_write_c;
    logic       reg_dst_c, mem_to_reg_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    alu_ctl_t   alu_ctl_c;
    logic       pc_write_c, branch_c, illegal_c, bus_err_c;

    logic       rtype_ok;
    alu_ctl_t   rtype_alu;
    logic       mem_state;
    logic       timeout_hit;

    always_comb begin
        rtype_ok  = 1'b1;
        rtype_alu = ALU_ADD;
        case (bus.funct)
            FN_ADD:  rtype_alu = ALU_ADD;
            FN_SUB:  rtype_alu = ALU_SUB;
            FN_AND:  rtype_alu = ALU_AND;
            FN_OR:   rtype_alu = ALU_OR;
            FN_SLT:  rtype_alu = ALU_SLT;
            default: rtype_ok  = 1'b0;
        endcase
    end

    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == TIMEOUT_W);

    // The wait counter only survives consecutive not-ready cycles in the same memory state;
    // a timeout abort or any state change restarts it from zero.
    always_comb begin
        wait_d = '0;
        if (mem_state && !bus.mem_ready && !timeout_hit) begin
            wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal assigned below gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        mem_req_c    = 1'b0;
        i_or_d_c     = 1'b0;
        ir_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = SRCB_REG;
        pc_src_c     = 2'b00;
        alu_ctl_c    = ALU_ADD;
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        illegal_c    = 1'b0;
        bus_err_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_hit) begin
                    mem_req_c = 1'b0;
                    bus_err_c = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b_c = SRCB_IMMSH;
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (rtype_ok) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal_c = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                state_d     = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    mem_req_c = 1'b0;
                    bus_err_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                i_or_d_c    = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    mem_req_c   = 1'b0;
                    mem_write_c = 1'b0;
                    bus_err_c   = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_ctl_c   = rtype_alu;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_ctl_c   = ALU_SUB;
                pc_src_c    = PCSRC_ALUOUT;
                branch_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src_c   = PCSRC_JUMP;
                pc_write_c = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order the simulator evaluates blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Reset gates the outputs combinationally so a write in flight is dropped immediately.
    assign bus.mem_req       = rst & mem_req_c;
    assign bus.i_or_d        = rst & i_or_d_c;
    assign bus.ir_write      = rst & ir_write_c;
    assign bus.mem_write     = rst & mem_write_c;
    assign bus.reg_write     = rst & reg_write_c;
    assign bus.reg_dst       = rst & reg_dst_c;
    assign bus.mem_to_reg    = rst & mem_to_reg_c;
    assign bus.alu_src_a     = rst & alu_src_a_c;
    assign bus.alu_src_b     = rst ? alu_src_b_c : 2'b00;
    assign bus.pc_src        = rst ? pc_src_c : 2'b00;
    assign bus.alu_control   = rst ? alu_ctl_c : ALU_ADD;
    assign bus.pc_en         = rst & (pc_write_c | (branch_c & bus.zero));
    assign bus.illegal_instr = rst & illegal_c;
    assign bus.bus_err       = rst & bus_err_c;
    assign state_o           = state_q;

`ifdef MIPS_CTRL_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    // Only normal completions retire; illegal and timeout aborts never reach these paths.
    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                    (state_q == S_ADDIWB) || (state_q == S_JUMP) ||
                    ((state_q == S_MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (retire) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    // Counter width only matters when the counters are built.
    if (CNT_W == 0) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-level model walks each opcode's
// step list and predicts every cycle's outputs from the per-step control table.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;
    localparam int TO = 4;
    localparam int CW = 32;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
    localparam int S_MEMWRITE = 5, S_EXECUTE = 6, S_ALUWB = 7, S_BRANCH = 8;
    localparam int S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();
    logic [3:0] state_o;
`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [CW-1:0] cycle_cnt, instr_cnt;
`endif

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
`ifdef MIPS_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctl;
        logic [1:0] pc_src;
        logic       pc_en, ill, berr;
    } obs_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   model_cycles = 0;
    int   model_retired = 0;
    logic cur_zero = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t get_obs();
        obs_t o;
        o.st = state_o;
        o.mem_req = bus.mem_req;       o.i_or_d = bus.i_or_d;
        o.ir_write = bus.ir_write;     o.mem_write = bus.mem_write;
        o.reg_write = bus.reg_write;   o.reg_dst = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg; o.alu_src_a = bus.alu_src_a;
        o.alu_src_b = bus.alu_src_b;   o.alu_ctl = bus.alu_control;
        o.pc_src = bus.pc_src;         o.pc_en = bus.pc_en;
        o.ill = bus.illegal_instr;     o.berr = bus.bus_err;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t r = '0;
        r.alu_ctl = 3'b010;
        return r;
    endfunction

    // R-type funct table: returns 1 with the ALU code when funct is decodable.
    function automatic bit funct_alu(input logic [5:0] f, output logic [2:0] a);
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ops [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        a = 3'b010;
        for (int i = 0; i < 5; i++) begin
            if (fns[i] == f) begin
                a = ops[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Per-step control table; abort means the wait limit hit in a memory step.
    function automatic obs_t expect_obs(input int st, input bit rdy, input bit z, input bit abort,
                                        input bit ill, input logic [2:0] ralu);
        obs_t e = '0;
        e.st = st[3:0];
        e.alu_ctl = 3'b010;
        case (st)
            S_FETCH:    begin e.alu_src_b = 2'b01; e.mem_req = !abort; e.ir_write = rdy;
                              e.pc_en = rdy; e.berr = abort; end
            S_DECODE:   begin e.alu_src_b = 2'b11; e.ill = ill; end
            S_MEMADR:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            S_MEMREAD:  begin e.mem_req = !abort; e.i_or_d = 1'b1; e.berr = abort; end
            S_MEMWB:    begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            S_MEMWRITE: begin e.mem_req = !abort; e.i_or_d = 1'b1; e.mem_write = !abort;
                              e.berr = abort; end
            S_EXECUTE:  begin e.alu_src_a = 1'b1; e.alu_ctl = ralu; end
            S_ALUWB:    begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            S_BRANCH:   begin e.alu_src_a = 1'b1; e.alu_ctl = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
            S_ADDIEX:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            S_ADDIWB:   e.reg_write = 1'b1;
            S_JUMP:     begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            default:    e = reset_obs();
        endcase
        return e;
    endfunction

    task automatic drive(input bit rdy);
        bus.mem_ready = rdy;
        cur_zero = 1'($urandom_range(0, 1));
        bus.zero = cur_zero;
    endtask

    task automatic visit(input obs_t e);
        #2;
        check($sformatf("state%0d", e.st), {10'b0, get_obs()}, {10'b0, e});
        @(posedge clk);
        #1;
        model_cycles++;
    endtask

    task automatic plain_step(input int st, input logic [2:0] ralu);
        drive(1'($urandom_range(0, 1)));
        visit(expect_obs(st, bus.mem_ready, cur_zero, 1'b0, 1'b0, ralu));
    endtask

    // Memory step: ready after w not-ready cycles; aborts after TO consecutive not-ready ones.
    task automatic mem_step(input int st, input int w, output bit aborted);
        bit rdy, ab;
        aborted = 1'b0;
        for (int k = 0; k <= TO; k++) begin
            rdy = (k >= w);
            ab = !rdy && (k == TO);
            drive(rdy);
            visit(expect_obs(st, rdy, cur_zero, ab, 1'b0, 3'b010));
            if (ab) begin
                aborted = 1'b1;
                break;
            end
            if (rdy) break;
        end
    endtask

    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int fw, input int mw,
                             input logic bz, input bit rst_wb);
        logic [2:0] ralu;
        bit fn_ok, legal, ab;
        bus.opcode = opc;
        bus.funct = fn;
        fn_ok = funct_alu(fn, ralu);
        legal = (opc == OP_R && fn_ok) || opc == OP_LW || opc == OP_SW || opc == OP_BEQ ||
                opc == OP_ADDI || opc == OP_J;
        mem_step(S_FETCH, fw, ab);
        if (ab) return;
        drive(1'($urandom_range(0, 1)));
        visit(expect_obs(S_DECODE, 1'b0, cur_zero, 1'b0, !legal, ralu));
        if (!legal) return;
        case (opc)
            OP_R: begin
                plain_step(S_EXECUTE, ralu);
                plain_step(S_ALUWB, ralu);
                model_retired++;
            end
            OP_LW: begin
                plain_step(S_MEMADR, ralu);
                mem_step(S_MEMREAD, mw, ab);
                if (ab) return;
                if (rst_wb) begin
                    drive(1'b1);
                    #2;
                    check("wb_before_rst", {10'b0, get_obs()},
                          {10'b0, expect_obs(S_MEMWB, 1'b1, cur_zero, 1'b0, 1'b0, ralu)});
                    rst = 1'b0;
                    #1;
                    check("wb_in_rst", {10'b0, get_obs()}, {10'b0, reset_obs()});
                    @(posedge clk);
                    #1;
                    check("rst_hold", {10'b0, get_obs()}, {10'b0, reset_obs()});
                    rst = 1'b1;
                    model_cycles = 0;
                    model_retired = 0;
                    return;
                end
                plain_step(S_MEMWB, ralu);
                model_retired++;
            end
            OP_SW: begin
                plain_step(S_MEMADR, ralu);
                mem_step(S_MEMWRITE, mw, ab);
                if (!ab) model_retired++;
            end
            OP_BEQ: begin
                bus.mem_ready = 1'($urandom_range(0, 1));
                cur_zero = bz;
                bus.zero = bz;
                visit(expect_obs(S_BRANCH, 1'b0, bz, 1'b0, 1'b0, ralu));
                model_retired++;
            end
            OP_ADDI: begin
                plain_step(S_ADDIEX, ralu);
                plain_step(S_ADDIWB, ralu);
                model_retired++;
            end
            default: begin
                plain_step(S_JUMP, ralu);
                model_retired++;
            end
        endcase
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 2));
    endfunction

    initial begin
        logic [5:0] opc, fn;
        logic [2:0] dummy;
        int sel;
        bus.opcode = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #2;
            check("reset_outputs", {10'b0, get_obs()}, {10'b0, reset_obs()});
            @(posedge clk);
            #1;
        end
        rst = 1'b1;

        for (int i = 0; i < 3; i++) run_instr(OP_ADDI, 6'($urandom), 0, 0, 1'b0, 1'b0);
`ifdef MIPS_CTRL_PERF_CNT_EN
        check("three_addi_instr_cnt", instr_cnt, 32'd3);
        check("three_addi_cycle_cnt", cycle_cnt, 32'd12);
`endif

        run_instr(OP_R, 6'b100000, 0, 0, 1'b0, 1'b0);
        run_instr(OP_R, 6'b101010, 1, 0, 1'b0, 1'b0);
        run_instr(OP_LW, 6'h00, 0, 3, 1'b0, 1'b0);
        run_instr(OP_BEQ, 6'h00, 0, 0, 1'b1, 1'b0);
        run_instr(OP_BEQ, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'b111111, 6'h20, 0, 0, 1'b0, 1'b0);
        run_instr(OP_R, 6'b000111, 0, 0, 1'b0, 1'b0);
        run_instr(OP_SW, 6'h00, 0, TO + 1, 1'b0, 1'b0);
        run_instr(OP_SW, 6'h00, 0, TO, 1'b0, 1'b0);
        run_instr(OP_J, 6'h00, TO + 1, 0, 1'b0, 1'b0);
        run_instr(OP_J, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(OP_LW, 6'h00, 0, TO + 1, 1'b0, 1'b0);
        run_instr(OP_LW, 6'h00, 0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            fn = 6'($urandom);
            case (sel)
                0, 1, 2: begin
                    opc = OP_R;
                    case ($urandom_range(0, 4))
                        0: fn = 6'b100000;
                        1: fn = 6'b100010;
                        2: fn = 6'b100100;
                        3: fn = 6'b100101;
                        default: fn = 6'b101010;
                    endcase
                end
                3: opc = OP_LW;
                4: opc = OP_SW;
                5: opc = OP_BEQ;
                6: opc = OP_ADDI;
                7: opc = OP_J;
                8: begin
                    opc = 6'($urandom);
                    if (opc == OP_R || opc == OP_LW || opc == OP_SW || opc == OP_BEQ ||
                        opc == OP_ADDI || opc == OP_J) opc = 6'b111111;
                end
                default: begin
                    opc = OP_R;
                    if (funct_alu(fn, dummy)) fn = 6'b000000;
                end
            endcase
            run_instr(opc, fn, pick_wait(), pick_wait(), 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef MIPS_CTRL_PERF_CNT_EN
        check("final_cycle_cnt", cycle_cnt, 32'(model_cycles));
        check("final_instr_cnt", instr_cnt, 32'(model_retired));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
